// File: rtl/repairval_module_initiator_pkg.sv
// repairval_module_initiator_pkg: MBINIT REPAIRVAL message codes, initiator states and decode helpers.
package repairval_module_initiator_pkg;
  localparam logic [3:0] MSG_NONE        = 4'd0;
  localparam logic [3:0] MSG_INIT_REQ    = 4'd1;
  localparam logic [3:0] MSG_INIT_RESP   = 4'd2;
  localparam logic [3:0] MSG_RESULT_REQ  = 4'd3;
  localparam logic [3:0] MSG_RESULT_RESP = 4'd4;
  localparam logic [3:0] MSG_DONE_REQ    = 4'd5;
  localparam logic [3:0] MSG_DONE_RESP   = 4'd6;
  typedef enum logic [3:0] {
    ST_IDLE, ST_CHK_BUSY_INIT, ST_INIT_REQ, ST_WAIT_INIT_RESP, ST_SEND_PATTERN,
    ST_CHK_BUSY_RESULT, ST_RESULT_REQ, ST_WAIT_RESULT_RESP, ST_CHK_BUSY_DONE,
    ST_DONE_REQ, ST_WAIT_DONE_RESP, ST_DONE, ST_ERROR
  } state_t;
  function automatic logic [3:0] tx_code(input state_t s);
    return s == ST_INIT_REQ ? MSG_INIT_REQ : s == ST_RESULT_REQ ? MSG_RESULT_REQ :
           s == ST_DONE_REQ ? MSG_DONE_REQ : MSG_NONE;
  endfunction
  // A response is accepted both in its request state and in the following wait state
  function automatic logic [3:0] resp_code(input state_t s);
    return (s == ST_INIT_REQ   || s == ST_WAIT_INIT_RESP)   ? MSG_INIT_RESP :
           (s == ST_RESULT_REQ || s == ST_WAIT_RESULT_RESP) ? MSG_RESULT_RESP :
           (s == ST_DONE_REQ   || s == ST_WAIT_DONE_RESP)   ? MSG_DONE_RESP : MSG_NONE;
  endfunction
  function automatic logic is_parked(input state_t s);
    return s == ST_IDLE || s == ST_DONE || s == ST_ERROR;
  endfunction
endpackage

// File: rtl/repairval_module_initiator_if.sv
// repairval_module_initiator_if: sideband, pattern and status signals of the REPAIRVAL initiator.
interface repairval_module_initiator_if;
  logic       i_REPAIRCLK_end;
  logic [3:0] i_Rx_SbMessage;
  logic       i_msg_valid;
  logic       i_Busy_SideBand;
  logic       i_falling_edge_busy;
  logic       i_VAL_Result_logged;
  logic       i_val_pattern_done;
  logic [3:0] o_TX_SbMessage;
  logic       o_ValidOutDatat_Module;
  logic       o_val_pattern_en;
  logic       o_VAL_Result;
  logic       o_MBINIT_REPAIRVAL_Module_end;
  logic       o_timeout_error;
  modport master (
    input  i_REPAIRCLK_end, i_Rx_SbMessage, i_msg_valid, i_Busy_SideBand,
           i_falling_edge_busy, i_VAL_Result_logged, i_val_pattern_done,
    output o_TX_SbMessage, o_ValidOutDatat_Module, o_val_pattern_en, o_VAL_Result,
           o_MBINIT_REPAIRVAL_Module_end, o_timeout_error
  );
  modport slave (
    output i_REPAIRCLK_end, i_Rx_SbMessage, i_msg_valid, i_Busy_SideBand,
           i_falling_edge_busy, i_VAL_Result_logged, i_val_pattern_done,
    input  o_TX_SbMessage, o_ValidOutDatat_Module, o_val_pattern_en, o_VAL_Result,
           o_MBINIT_REPAIRVAL_Module_end, o_timeout_error
  );
endinterface

// File: rtl/repairval_module_initiator_mbinit_state_timer.sv
// mbinit_state_timer: per-state dwell counter; expire flags the last allowed cycle in a state.
module mbinit_state_timer #(
  parameter int TIMEOUT_CYCLES = 800000
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);
  localparam int W = $clog2(TIMEOUT_CYCLES);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = i_clear ? '0 : i_enable ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign o_expire = cnt_q == W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/repairval_module_initiator.sv
// repairval_module_initiator: Module-side MBINIT.REPAIRVAL initiator FSM with registered output decode.
module repairval_module_initiator
  import repairval_module_initiator_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 800000
) (
  input logic                          CLK,
  input logic                          rst_n,
  repairval_module_initiator_if.master bus
);
  state_t     state_q, state_d;
  logic [3:0] tx_q, tx_d;
  logic       vld_q, vld_d, pat_q, pat_d, val_q, val_d, end_q, end_d, err_q, err_d;
  logic       rsp_ok, expire, tmr_clear;
  assign tmr_clear = state_d != state_q || is_parked(state_q);
  mbinit_state_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .CLK(CLK), .rst_n(rst_n), .i_clear(tmr_clear), .i_enable(bus.i_REPAIRCLK_end), .o_expire(expire)
  );
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    rsp_ok  = bus.i_msg_valid && bus.i_Rx_SbMessage == resp_code(state_q);
    case (state_q)
      ST_IDLE:             state_d = bus.i_REPAIRCLK_end ? ST_CHK_BUSY_INIT : ST_IDLE;
      ST_CHK_BUSY_INIT:    state_d = bus.i_Busy_SideBand ? state_q : ST_INIT_REQ;
      ST_INIT_REQ:         state_d = rsp_ok ? ST_SEND_PATTERN : bus.i_falling_edge_busy ? ST_WAIT_INIT_RESP : state_q;
      ST_WAIT_INIT_RESP:   state_d = rsp_ok ? ST_SEND_PATTERN : state_q;
      ST_SEND_PATTERN:     state_d = bus.i_val_pattern_done ? ST_CHK_BUSY_RESULT : state_q;
      ST_CHK_BUSY_RESULT:  state_d = bus.i_Busy_SideBand ? state_q : ST_RESULT_REQ;
      ST_RESULT_REQ:       state_d = rsp_ok ? ST_CHK_BUSY_DONE : bus.i_falling_edge_busy ? ST_WAIT_RESULT_RESP : state_q;
      ST_WAIT_RESULT_RESP: state_d = rsp_ok ? ST_CHK_BUSY_DONE : state_q;
      ST_CHK_BUSY_DONE:    state_d = bus.i_Busy_SideBand ? state_q : ST_DONE_REQ;
      ST_DONE_REQ:         state_d = rsp_ok ? ST_DONE : bus.i_falling_edge_busy ? ST_WAIT_DONE_RESP : state_q;
      ST_WAIT_DONE_RESP:   state_d = rsp_ok ? ST_DONE : state_q;
      default:             state_d = state_q;
    endcase
    // A legal transition on the expiry cycle takes precedence over the timeout
    if (state_d == state_q && expire && !is_parked(state_q)) state_d = ST_ERROR;
    if (rsp_ok && (state_q == ST_RESULT_REQ || state_q == ST_WAIT_RESULT_RESP)) val_d = bus.i_VAL_Result_logged;
    if (!bus.i_REPAIRCLK_end) begin
      state_d = ST_IDLE;
      val_d   = 1'b0;
    end
    tx_d  = tx_code(state_d);
    vld_d = tx_d != MSG_NONE;
    pat_d = state_d == ST_SEND_PATTERN;
    end_d = state_d == ST_DONE;
    err_d = state_d == ST_ERROR;
  end
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tx_q    <= MSG_NONE;
      vld_q   <= 1'b0;
      pat_q   <= 1'b0;
      val_q   <= 1'b0;
      end_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      vld_q   <= vld_d;
      pat_q   <= pat_d;
      val_q   <= val_d;
      end_q   <= end_d;
      err_q   <= err_d;
    end
  assign bus.o_TX_SbMessage                = tx_q;
  assign bus.o_ValidOutDatat_Module        = vld_q;
  assign bus.o_val_pattern_en              = pat_q;
  assign bus.o_VAL_Result                  = val_q;
  assign bus.o_MBINIT_REPAIRVAL_Module_end = end_q;
  assign bus.o_timeout_error               = err_q;
endmodule
